// File: rtl/ram_master_if.sv
// ram_master_if: core request/response and RAM strobe bundle between ram_master and its environment
interface ram_master_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_cs;
  logic        mem_we;
  logic        mem_re;
  logic [3:0]  mem_byte_we;
  logic [31:0] mem_waddr;
  logic [31:0] mem_raddr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  modport master (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, resp_ready, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_cs, mem_we, mem_re, mem_byte_we, mem_waddr, mem_raddr, mem_wdata
  );
  modport slave (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, resp_ready, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mem_cs, mem_we, mem_re, mem_byte_we, mem_waddr, mem_raddr, mem_wdata
  );
endinterface

// File: rtl/ram_master.sv
// ram_master: core load/store to byte-lane RAM bridge; define RAM_MASTER_BOUND_CHECK_EN to reject words at index >= DEPTH
module ram_master #(
  parameter int DEPTH = 512,
  parameter int WIDTH = 32
) (
  input logic clk,
  input logic rst,
  ram_master_if.master bus
);
`ifdef RAM_MASTER_BOUND_CHECK_EN
  localparam bit BOUND_EN = 1'b1;
`else
  localparam bit BOUND_EN = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, ACCESS, RDATA, RESP} state_t;
  state_t state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0] size_q, size_d;
  logic we_q, we_d, uns_q, uns_d, err_q, err_d, valid_q, valid_d;
  logic [WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic oob, bad, acc;
  logic [31:0] sh, ext;
  logic [3:0] lanes;
  assign oob = BOUND_EN && ({2'b00, bus.req_addr[31:2]} >= 32'(DEPTH));
  assign bad = bus.req_size == 2'b11 || (bus.req_size == 2'b01 && bus.req_addr[0])
            || (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00) || oob;
  assign sh = bus.mem_rdata >> {addr_q[1:0], 3'b000};
  assign ext = size_q == 2'b00 ? {{24{~uns_q & sh[7]}}, sh[7:0]}
             : size_q == 2'b01 ? {{16{~uns_q & sh[15]}}, sh[15:0]} : sh;
  assign lanes = size_q == 2'b00 ? 4'b0001 << addr_q[1:0]
               : size_q == 2'b01 ? (addr_q[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    size_d  = size_q;
    we_d    = we_q;
    uns_d   = uns_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: if (bus.req_valid) begin
        addr_d  = bus.req_addr;
        size_d  = bus.req_size;
        we_d    = bus.req_we;
        uns_d   = bus.req_unsigned;
        wdata_d = bus.req_wdata;
        rdata_d = '0;
        err_d   = bad;
        valid_d = bad;
        state_d = bad ? RESP : ACCESS;
      end
      ACCESS: begin
        valid_d = we_q;
        state_d = we_q ? RESP : RDATA;
      end
      RDATA: begin
        rdata_d = ext;
        valid_d = 1'b1;
        state_d = RESP;
      end
      default: if (bus.resp_ready) begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      size_q  <= '0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      we_q    <= we_d;
      uns_q   <= uns_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      valid_q <= valid_d;
    end
  end
  assign acc             = state_q == ACCESS;
  assign bus.req_ready   = state_q == IDLE;
  assign bus.resp_valid  = valid_q;
  assign bus.resp_rdata  = rdata_q;
  assign bus.resp_err    = err_q;
  assign bus.mem_cs      = acc;
  assign bus.mem_we      = acc & we_q;
  assign bus.mem_re      = acc & ~we_q;
  assign bus.mem_byte_we = acc & we_q ? lanes : 4'b0000;
  assign bus.mem_waddr   = acc ? {2'b00, addr_q[31:2]} : 32'd0;
  assign bus.mem_raddr   = acc ? {2'b00, addr_q[31:2]} : 32'd0;
  assign bus.mem_wdata   = acc & we_q ? wdata_q : 32'd0;
endmodule

// File: tb/tb_ram_master.sv
// tb_ram_master: directed load/store/error/backpressure/reset steps with a response scoreboard
module tb_ram_master;
  typedef struct {logic [31:0] rdata; logic err;} exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  exp_t sb[$];
  exp_t e;
  ram_master_if bus();
  ram_master #(.DEPTH(512), .WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic pop_check(input string tag);
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: observed empty scoreboard expected entry", tag);
    end else begin
      e = sb.pop_front();
      check({tag, "_rdata"}, bus.resp_rdata, e.rdata);
      check({tag, "_err"}, 32'(bus.resp_err), 32'(e.err));
    end
  endtask
  task automatic run(input string tag, input logic we, input logic [1:0] size, input logic uns,
                     input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] mrd,
                     input logic [31:0] erd, input logic eerr, input int elat,
                     input logic [3:0] ebe, input logic [31:0] eidx);
    int lat, ncs;
    @(negedge clk);
    check({tag, "_req_ready"}, 32'(bus.req_ready), 1);
    bus.req_valid = 1'b1;
    bus.req_we = we;
    bus.req_size = size;
    bus.req_unsigned = uns;
    bus.req_addr = addr;
    bus.req_wdata = wdata;
    bus.mem_rdata = mrd;
    sb.push_back('{erd, eerr});
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    lat = 1;
    ncs = 0;
    while (!bus.resp_valid && lat < 10) begin
      if (bus.mem_cs) begin
        ncs++;
        check({tag, "_byte_we"}, 32'(bus.mem_byte_we), 32'(ebe));
        check({tag, "_mem_we"}, 32'(bus.mem_we), 32'(we));
        check({tag, "_mem_re"}, 32'(bus.mem_re), 32'(!we));
        check({tag, "_waddr"}, bus.mem_waddr, eidx);
        check({tag, "_raddr"}, bus.mem_raddr, eidx);
        if (we) check({tag, "_wdata"}, bus.mem_wdata, wdata);
      end
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(elat));
    check({tag, "_cs_cycles"}, 32'(ncs), eerr ? 0 : 1);
    check({tag, "_resp_mem_cs"}, 32'(bus.mem_cs), 0);
    pop_check(tag);
    @(posedge clk);
    @(negedge clk);
    check({tag, "_resp_done"}, 32'(bus.resp_valid), 0);
  endtask
  initial begin
    bus.req_valid = 1'b0;
    bus.req_we = 1'b0;
    bus.req_size = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    bus.resp_ready = 1'b1;
    bus.mem_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_req_ready", 32'(bus.req_ready), 1);
    check("rst_resp_valid", 32'(bus.resp_valid), 0);
    check("rst_resp_err", 32'(bus.resp_err), 0);
    check("rst_resp_rdata", bus.resp_rdata, 0);
    check("rst_mem_strobes", {28'd0, bus.mem_cs, bus.mem_we, bus.mem_re, 1'b0}, 0);
    check("rst_mem_byte_we", 32'(bus.mem_byte_we), 0);
    check("rst_mem_addr", bus.mem_waddr | bus.mem_raddr | bus.mem_wdata, 0);
    run("byte_store", 1, 2'b00, 0, 32'h6, 32'hAB, 32'h0, 32'h0, 0, 2, 4'b0100, 32'd1);
    run("half_load_s", 0, 2'b01, 0, 32'h2, 32'h0, 32'h8001_1234, 32'hFFFF_8001, 0, 3, 4'b0000, 32'd0);
    run("half_load_u", 0, 2'b01, 1, 32'h2, 32'h0, 32'h8001_1234, 32'h0000_8001, 0, 3, 4'b0000, 32'd0);
    run("word_misalign", 0, 2'b10, 0, 32'h5, 32'h0, 32'hFFFF_FFFF, 32'h0, 1, 1, 4'b0000, 32'd0);
    run("byte_load_s", 0, 2'b00, 0, 32'h1, 32'h0, 32'h1234_F078, 32'hFFFF_FFF0, 0, 3, 4'b0000, 32'd0);
    run("byte_load_u3", 0, 2'b00, 1, 32'h7, 32'h0, 32'h9A34_F078, 32'h0000_009A, 0, 3, 4'b0000, 32'd1);
    run("word_load", 0, 2'b10, 0, 32'h10, 32'h0, 32'hCAFE_F00D, 32'hCAFE_F00D, 0, 3, 4'b0000, 32'd4);
    run("half_store_hi", 1, 2'b01, 0, 32'h12, 32'h0000_BEEF, 32'h0, 32'h0, 0, 2, 4'b1100, 32'd4);
    run("half_store_lo", 1, 2'b01, 0, 32'h20, 32'h0000_1234, 32'h0, 32'h0, 0, 2, 4'b0011, 32'd8);
    run("word_store", 1, 2'b10, 0, 32'h24, 32'hDEAD_BEEF, 32'h0, 32'h0, 0, 2, 4'b1111, 32'd9);
    run("size_illegal", 1, 2'b11, 0, 32'h0, 32'h1, 32'h0, 32'h0, 1, 1, 4'b0000, 32'd0);
    run("half_misalign", 0, 2'b01, 0, 32'h3, 32'h0, 32'h0, 32'h0, 1, 1, 4'b0000, 32'd0);
`ifdef RAM_MASTER_BOUND_CHECK_EN
    run("bound_oob", 0, 2'b10, 0, 32'h800, 32'h0, 32'h1111_2222, 32'h0, 1, 1, 4'b0000, 32'd0);
    run("bound_last", 0, 2'b10, 0, 32'h7FC, 32'h0, 32'h1111_2222, 32'h1111_2222, 0, 3, 4'b0000, 32'h1FF);
`else
    run("bound_pass", 0, 2'b10, 0, 32'h800, 32'h0, 32'h1111_2222, 32'h1111_2222, 0, 3, 4'b0000, 32'h200);
`endif
    // response backpressure with a second request waiting
    @(negedge clk);
    bus.resp_ready = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_we = 1'b0;
    bus.req_size = 2'b01;
    bus.req_unsigned = 1'b1;
    bus.req_addr = 32'h2;
    bus.mem_rdata = 32'h8001_1234;
    sb.push_back('{32'h0000_8001, 1'b0});
    @(posedge clk);
    @(negedge clk);
    bus.req_we = 1'b1;
    bus.req_size = 2'b10;
    bus.req_addr = 32'h40;
    bus.req_wdata = 32'h1122_3344;
    for (int i = 0; i < 8 && !bus.resp_valid; i++) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check("bp_resp_valid", 32'(bus.resp_valid), 1);
      check("bp_resp_rdata", bus.resp_rdata, 32'h0000_8001);
      check("bp_req_ready", 32'(bus.req_ready), 0);
      check("bp_mem_cs", 32'(bus.mem_cs), 0);
      @(negedge clk);
    end
    pop_check("bp");
    bus.resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_idle_ready", 32'(bus.req_ready), 1);
    check("bp_idle_cs", 32'(bus.mem_cs), 0);
    check("bp_idle_valid", 32'(bus.resp_valid), 0);
    sb.push_back('{32'h0, 1'b0});
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("bp2_mem_cs", 32'(bus.mem_cs), 1);
    check("bp2_byte_we", 32'(bus.mem_byte_we), 32'hF);
    check("bp2_waddr", bus.mem_waddr, 32'h10);
    check("bp2_wdata", bus.mem_wdata, 32'h1122_3344);
    @(negedge clk);
    check("bp2_resp_valid", 32'(bus.resp_valid), 1);
    pop_check("bp2");
    @(posedge clk);
    // reset while a load is in its access cycle
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we = 1'b0;
    bus.req_size = 2'b10;
    bus.req_addr = 32'h8;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("rst_acc_mem_re", 32'(bus.mem_re), 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_acc_mem_re_after", 32'(bus.mem_re), 0);
    check("rst_acc_mem_cs_after", 32'(bus.mem_cs), 0);
    check("rst_acc_resp_valid", 32'(bus.resp_valid), 0);
    check("rst_acc_req_ready", 32'(bus.req_ready), 1);
    @(negedge clk);
    check("rst_acc_still_idle", {30'd0, bus.resp_valid, bus.mem_cs}, 0);
    check("sb_empty", 32'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ram_master.md
RAM_MASTER -- requirements
Module: ram_master

Interface
REQ-001 SHALL have parameter DEPTH, default 512, meaning the word count of the attached RAM.
REQ-002 SHALL have parameter WIDTH, default 32, meaning the RAM word width; only 32 is supported.
REQ-003 clk  input  1  rising-edge clock for all logic.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req_valid  input  1  core presents an access.
REQ-006 req_ready  output  1  block accepts an access; high only in IDLE.
REQ-007 req_we  input  1  1=store, 0=load.
REQ-008 req_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-009 req_unsigned  input  1  zero-extend load when 1, sign-extend when 0.
REQ-010 req_addr  input  32  byte address.
REQ-011 req_wdata  input  32  store data, right-justified.
REQ-012 resp_valid  output  1  response available.
REQ-013 resp_ready  input  1  core consumes response.
REQ-014 resp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-015 resp_err  output  1  access rejected, with no memory strobe issued.
REQ-016 mem_cs, mem_we, mem_re  output  1 each  RAM chip select, write strobe and read strobe.
REQ-017 mem_byte_we  output  4  RAM byte-lane enable.
REQ-018 mem_waddr, mem_raddr  output  32 each  RAM word index.
REQ-019 mem_wdata  output  32  RAM write data.
REQ-020 mem_rdata  input  32  RAM read data, valid one cycle after mem_re.

Function
REQ-021 SHALL implement the FSM IDLE->ACCESS->(load: RDATA)->RESP->IDLE; an error goes IDLE->RESP.
- REQ-022 SHALL accept a request on req_valid&&req_ready and register addr, size, we, unsigned and wdata.
REQ-023 SHALL flag an error for req_size==11, a half access with addr[0]=1, or a word access with addr[1:0]!=0.
REQ-024 SHALL drive mem_cs=1 and mem_waddr=mem_raddr=addr[31:2] only in ACCESS, and hold all mem_* outputs at 0 in every other state.
REQ-025 Store in ACCESS SHALL assert mem_we=1 and mem_wdata=registered wdata, unshifted.
- REQ-025 byte_we SHALL be, by size and lane: byte -> 0001/0010/0100/1000 for addr[1:0]=0..3; half -> 0011 (addr[1]=0) or 1100 (addr[1]=1); word -> 1111.
REQ-026 Load in ACCESS SHALL assert mem_re=1 with mem_byte_we=0000.
REQ-027 In RDATA, SHALL shift mem_rdata right by 8*addr[1:0], extend the byte or half per req_unsigned, and register the result into resp_rdata.
REQ-028 In RESP, SHALL hold resp_valid=1 and hold resp_rdata/resp_err stable until resp_ready, then return to IDLE.
REQ-029 Latency with resp_ready=1 and acceptance at cycle T: store resp_valid at T+2; load at T+3; error at T+1.
REQ-030 SHALL set req_ready=0 outside IDLE, and SHALL ignore a new req_valid until IDLE is re-entered.

Reset
REQ-031 While rst=1 at a clock edge, SHALL enter IDLE and clear resp_valid, resp_err, resp_rdata and all registered request fields.
REQ-032 Reset in any state, including ACCESS or RESP, SHALL drop the pending access and issue no mem strobe in the following cycle.
REQ-033 After reset, req_ready SHALL be 1 and all mem_* outputs SHALL be 0.

Configuration
REQ-034 With macro RAM_MASTER_BOUND_CHECK_EN defined, a request with addr[31:2] >= DEPTH SHALL be treated as an error (resp_err=1, no strobe).
REQ-035 Without RAM_MASTER_BOUND_CHECK_EN, SHALL perform no range check and pass addr[31:2] through unchanged.

Verification
REQ-036 Byte store addr=0x0000_0006, wdata=0x0000_00AB -> single ACCESS cycle: mem_we=1, byte_we=0100, waddr=1, wdata=0x0000_00AB; resp_valid at T+2.
REQ-037 Signed half load addr=0x0000_0002, mem_rdata=0x8001_1234 -> resp_rdata=0xFFFF_8001; unsigned -> 0x0000_8001; resp_valid at T+3.
REQ-038 Word load addr=0x0000_0005 -> resp_err=1 at T+1, resp_rdata=0, mem_cs never asserted.
REQ-039 Hold resp_ready=0 for 4 cycles while req_valid=1 -> resp_valid and data stable, req_ready=0, no second access until after the handshake.
REQ-040 Assert rst during a load's ACCESS -> next cycle IDLE, mem_re=0, resp_valid=0, req_ready=1.
REQ-041 With RAM_MASTER_BOUND_CHECK_EN and DEPTH=512, load addr=0x0000_0800 -> resp_err=1; without the macro -> mem_raddr=0x200 and a normal response.
